// File: rtl/musicbox_song_player_pkg.sv
// Shared types and constants for the music box song player and its state controller.
package musicbox_pkg;

    typedef enum logic [1:0] {
        SP_IDLE  = 2'd0,
        SP_PRIME = 2'd1,
        SP_PLAY  = 2'd2,
        SP_DONE  = 2'd3
    } song_player_state_t;

    localparam logic [7:0] SILENCE_LEVEL   = 8'd128;
    // First song state of MusicBoxStateController; song k lives at SONG_STATE_BASE + k.
    localparam logic [4:0] SONG_STATE_BASE = 5'd1;

endpackage

// File: rtl/musicbox_song_player_if.sv
// Song ROM bus: byte address out, data back one cycle after the address changes.
interface musicbox_song_player_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] romAddress;
    logic [7:0]            romData;

    modport master (output romAddress, input  romData);
    modport slave  (input  romAddress, output romData);
endinterface

// File: rtl/musicbox_song_player_sample_tick_generator.sv
// One-cycle sample tick every CLOCK_DIVIDE cycles while enabled, phase restarted on enable.
module sample_tick_generator #(
    parameter int CLOCK_DIVIDE = 3125
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);
    localparam int CW = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (!enable || count_q == '0) begin
            count_q <= CW'(CLOCK_DIVIDE - 1);
        end else begin
            count_q <= count_q - CW'(1);
        end
    end

    assign tick = enable && (count_q == '0);
endmodule

// File: rtl/musicbox_song_player.sv
// Streams one selected song from ROM at the sample rate, with attenuation, looping and user abort.
module musicbox_song_player
    import musicbox_pkg::*;
#(
    parameter int         CLOCK_DIVIDE     = 3125,
    parameter int         ADDR_WIDTH       = 16,
    parameter int         SONG_COUNT       = 4,
    parameter logic [4:0] FIRST_SONG_STATE = SONG_STATE_BASE,
    parameter int         ABORT_HOLDOFF    = 16000
) (
    input  logic                             clock_50Mhz,
    input  logic                             reset_n,
    input  logic [4:0]                       currentState,
    input  logic [SONG_COUNT*ADDR_WIDTH-1:0] songBase,
    input  logic [SONG_COUNT*ADDR_WIDTH-1:0] songLength,
    input  logic                             loopEnable,
    input  logic [2:0]                       volumeShift,
    input  logic                             userInput,
    musicbox_song_player_if.master           rom,
    output logic                             stateComplete,
    output logic [7:0]                       audioAmplitudeOutput,
    output logic [31:0]                      debugString
);
    localparam int HOLD_W = (ABORT_HOLDOFF > 0) ? $clog2(ABORT_HOLDOFF + 1) : 1;

    song_player_state_t    state_q;
    logic [2:0]            song_idx_q;
    logic [4:0]            song_state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] offset_q;
    logic [HOLD_W-1:0]     holdoff_q;
    logic [7:0]            amp_p1;
    logic                  done_q;
    logic                  user_p0;

    logic [4:0]            rel_state;
    logic                  song_hit;
    logic [2:0]            hit_idx;
    logic [ADDR_WIDTH-1:0] hit_base;
    logic [ADDR_WIDTH-1:0] cur_base;
    logic [ADDR_WIDTH-1:0] cur_len;
    logic                  holdoff_met;
    logic                  abort;
    logic                  tick;

    function automatic logic [ADDR_WIDTH-1:0] pick_song(
        input logic [SONG_COUNT*ADDR_WIDTH-1:0] table_v,
        input logic [2:0]                       k
    );
        return table_v[int'(k)*ADDR_WIDTH +: ADDR_WIDTH];
    endfunction

    // Centre on 128, arithmetic shift, re-centre; the result never leaves 0..255.
    function automatic logic [7:0] attenuate(input logic [7:0] sample, input logic [2:0] shift);
        logic signed [8:0] centred;
        logic signed [8:0] scaled;
        centred = $signed({1'b0, sample}) - 9'sd128;
        scaled  = (centred >>> shift) + 9'sd128;
        return 8'(scaled);
    endfunction

    assign rel_state   = currentState - FIRST_SONG_STATE;
    assign song_hit    = (currentState >= FIRST_SONG_STATE) && (int'(rel_state) < SONG_COUNT);
    assign hit_idx     = rel_state[2:0];
    assign hit_base    = pick_song(songBase, hit_idx);
    assign cur_base    = pick_song(songBase, song_idx_q);
    assign cur_len     = pick_song(songLength, song_idx_q);
    assign holdoff_met = (int'(holdoff_q) >= ABORT_HOLDOFF);
    assign abort       = userInput && !user_p0 && holdoff_met;

    sample_tick_generator #(
        .CLOCK_DIVIDE(CLOCK_DIVIDE)
    ) u_tick (
        .clock  (clock_50Mhz),
        .reset_n(reset_n),
        .enable (state_q == SP_PLAY),
        .tick   (tick)
    );

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SP_IDLE;
            song_idx_q   <= '0;
            song_state_q <= '0;
            addr_q       <= '0;
            offset_q     <= '0;
            holdoff_q    <= '0;
            amp_p1       <= SILENCE_LEVEL;
            done_q       <= 1'b0;
            user_p0      <= 1'b0;
        end else begin
            user_p0 <= userInput;
            if (state_q != SP_IDLE && currentState != song_state_q) begin
                state_q <= SP_IDLE;
                amp_p1  <= SILENCE_LEVEL;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    SP_IDLE: begin
                        amp_p1 <= SILENCE_LEVEL;
                        done_q <= 1'b0;
                        if (song_hit) begin
                            state_q      <= SP_PRIME;
                            song_idx_q   <= hit_idx;
                            song_state_q <= currentState;
                            addr_q       <= hit_base;
                            offset_q     <= '0;
                            holdoff_q    <= '0;
                        end
                    end
                    SP_PRIME: begin
                        if (cur_len == '0) begin
                            state_q <= SP_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= SP_PLAY;
                        end
                    end
                    SP_PLAY: begin
                        if (abort) begin
                            state_q <= SP_DONE;
                            done_q  <= 1'b1;
                            amp_p1  <= SILENCE_LEVEL;
                        end else if (tick) begin
                            // ROM data -> output stage, address advances on the same edge
                            amp_p1 <= attenuate(rom.romData, volumeShift);
                            if (!holdoff_met) holdoff_q <= holdoff_q + HOLD_W'(1);
                            if (offset_q == cur_len - ADDR_WIDTH'(1)) begin
                                if (loopEnable) begin
                                    offset_q <= '0;
                                    addr_q   <= cur_base;
                                end else begin
                                    state_q <= SP_DONE;
                                    done_q  <= 1'b1;
                                end
                            end else begin
                                offset_q <= offset_q + ADDR_WIDTH'(1);
                                addr_q   <= addr_q + ADDR_WIDTH'(1);
                            end
                        end
                    end
                    SP_DONE: begin
                        // The last sample is visible for the single cycle DONE is entered.
                        amp_p1 <= SILENCE_LEVEL;
                    end
                    default: state_q <= SP_IDLE;
                endcase
            end
        end
    end

    assign rom.romAddress         = addr_q;
    assign stateComplete          = done_q;
    assign audioAmplitudeOutput   = amp_p1;
    assign debugString            = {8'(song_idx_q), 8'(state_q), 16'(offset_q)};
endmodule

// File: tb/tb_musicbox_song_player.sv
// Bench for musicbox_song_player: directed scenarios with literal expectations plus a randomized run.
module tb_musicbox_song_player;
    localparam int CD   = 4;
    localparam int AW   = 16;
    localparam int SC   = 2;
    localparam int HOLD = 3;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [4:0]     currentState = 5'd0;
    logic [SC*AW-1:0] songBase   = {16'h0100, 16'h0000};
    logic [SC*AW-1:0] songLength = {16'd3, 16'd5};
    logic           loopEnable = 1'b0;
    logic [2:0]     volumeShift = 3'd0;
    logic           userInput = 1'b0;
    logic           stateComplete;
    logic [7:0]     audio;
    logic [31:0]    dbg;

    int rom_mode = 0;
    int rom_const = 0;
    int rom_xor = 0;
    int n_checks = 0;
    int n_errors = 0;

    musicbox_song_player_if #(.ADDR_WIDTH(AW)) rom_bus ();

    musicbox_song_player #(
        .CLOCK_DIVIDE    (CD),
        .ADDR_WIDTH      (AW),
        .SONG_COUNT      (SC),
        .FIRST_SONG_STATE(5'd1),
        .ABORT_HOLDOFF   (HOLD)
    ) dut (
        .clock_50Mhz         (clk),
        .reset_n             (reset_n),
        .currentState        (currentState),
        .songBase            (songBase),
        .songLength          (songLength),
        .loopEnable          (loopEnable),
        .volumeShift         (volumeShift),
        .userInput           (userInput),
        .rom                 (rom_bus),
        .stateComplete       (stateComplete),
        .audioAmplitudeOutput(audio),
        .debugString         (dbg)
    );

    always #5 clk = ~clk;

    function automatic int rom_fn(input int addr);
        if (rom_mode == 1) return rom_const & 255;
        return ((addr & 255) ^ rom_xor) & 255;
    endfunction

    always @(posedge clk) rom_bus.romData <= 8'(rom_fn(int'(rom_bus.romAddress)));

    function automatic int base_of(input int k);
        return int'(songBase[k*AW +: AW]);
    endfunction

    function automatic int len_of(input int k);
        return int'(songLength[k*AW +: AW]);
    endfunction

    // 128 + floor((d-128) / 2^sh)
    function automatic int att(input int d, input int sh);
        int v, p;
        v = d - 128;
        p = 1 << sh;
        if (v >= 0) return 128 + v / p;
        return 128 - ((-v + p - 1) / p);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 prime, 2 play, 3 done (listing order of the states).
    int m_mode = 0, m_song = 0, m_sstate = 0, m_addr = 0, m_off = 0;
    int m_samples = 0, m_pcyc = 0, m_out = 128, m_done = 0;
    bit m_prev_btn = 1'b0;

    always @(posedge clk or negedge reset_n) begin : model
        int  len, base, pos;
        bit  rise, tick_now;
        if (!reset_n) begin
            m_mode = 0; m_song = 0; m_sstate = 0; m_addr = 0; m_off = 0;
            m_samples = 0; m_pcyc = 0; m_out = 128; m_done = 0; m_prev_btn = 1'b0;
        end else begin
            rise = userInput && !m_prev_btn;
            m_prev_btn = userInput;
            if (m_mode != 0 && int'(currentState) != m_sstate) begin
                m_mode = 0; m_out = 128; m_done = 0;
            end else begin
                case (m_mode)
                    0: begin
                        m_out = 128; m_done = 0;
                        if (currentState >= 5'd1 && currentState <= 5'd2) begin
                            m_song = int'(currentState) - 1;
                            m_sstate = int'(currentState);
                            m_addr = base_of(m_song);
                            m_off = 0; m_samples = 0; m_mode = 1;
                        end
                    end
                    1: begin
                        if (len_of(m_song) == 0) begin m_mode = 3; m_done = 1; end
                        else begin m_mode = 2; m_pcyc = 0; end
                    end
                    2: begin
                        len = len_of(m_song);
                        base = base_of(m_song);
                        tick_now = (m_pcyc % CD) == CD - 1;
                        m_pcyc++;
                        if (rise && m_samples >= HOLD) begin
                            m_mode = 3; m_done = 1; m_out = 128;
                        end else if (tick_now) begin
                            m_out = att(rom_fn(m_addr), int'(volumeShift));
                            pos = m_samples % len;
                            m_samples++;
                            if (!loopEnable && pos == len - 1) begin
                                m_mode = 3; m_done = 1;
                            end else begin
                                m_off = m_samples % len;
                                m_addr = (base + m_off) % 65536;
                            end
                        end
                    end
                    default: m_out = 128;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        chk("romAddress", 32'(rom_bus.romAddress), 32'(m_addr));
        chk("audioAmplitudeOutput", 32'(audio), 32'(m_out));
        chk("stateComplete", 32'(stateComplete), 32'(m_done));
        chk("debugString", dbg, {8'(m_song), 8'(m_mode), 16'(m_off)});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_addr", 32'(rom_bus.romAddress), 32'h0);
        chk("reset_audio", 32'(audio), 32'd128);
        chk("reset_complete", 32'(stateComplete), 32'd0);
        chk("reset_debug", dbg, 32'h0);
        reset_n = 1'b1;
        step(2);

        // Song 0 full play: samples 0..4 at 4-cycle spacing
        currentState = 5'd1;
        step(1);
        chk("s0_prime_state", 32'(dbg[23:16]), 32'd1);
        chk("s0_prime_addr", 32'(rom_bus.romAddress), 32'h0000);
        step(1);
        chk("s0_play_state", 32'(dbg[23:16]), 32'd2);
        step(3);
        chk("s0_pre_tick", 32'(audio), 32'd128);
        step(1);
        chk("s0_sample0", 32'(audio), 32'd0);
        chk("s0_addr0", 32'(rom_bus.romAddress), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            step(3);
            chk("s0_hold", 32'(audio), 32'(i - 1));
            step(1);
            chk("s0_sample", 32'(audio), 32'(i));
            chk("s0_complete", 32'(stateComplete), 32'(i == 4));
            chk("s0_addr", 32'(rom_bus.romAddress), 32'((i < 4) ? i + 1 : 4));
        end
        step(1);
        chk("s0_after_audio", 32'(audio), 32'd128);
        chk("s0_after_complete", 32'(stateComplete), 32'd1);
        currentState = 5'd0;
        step(1);
        chk("s0_to_idle_complete", 32'(stateComplete), 32'd0);
        chk("s0_to_idle_state", 32'(dbg[23:16]), 32'd0);
        step(1);

        // Loop on song 1
        loopEnable = 1'b1;
        currentState = 5'd2;
        step(6);
        for (int t = 1; t <= 10; t++) begin
            chk("loop_addr", 32'(rom_bus.romAddress), 32'h100 + 32'(t % 3));
            chk("loop_audio", 32'(audio), 32'((t - 1) % 3));
            chk("loop_complete", 32'(stateComplete), 32'd0);
            if (t < 10) step(4);
        end
        currentState = 5'd0;
        loopEnable = 1'b0;
        step(2);

        // Attenuation
        rom_mode = 1; rom_const = 8'h00; volumeShift = 3'd1;
        currentState = 5'd1;
        step(6);
        chk("att_00_s1", 32'(audio), 32'd64);
        rom_const = 8'hFF; volumeShift = 3'd7;
        step(4);
        chk("att_ff_s7", 32'(audio), 32'd128);
        chk("att_playing", 32'(dbg[23:16]), 32'd2);
        rom_const = 8'hFF; volumeShift = 3'd1;
        step(4);
        chk("att_ff_s1", 32'(audio), 32'd191);
        rom_const = 8'h00; volumeShift = 3'd7;
        step(4);
        chk("att_00_s7", 32'(audio), 32'd127);
        currentState = 5'd0; rom_mode = 0; volumeShift = 3'd0;
        step(2);

        // Abort holdoff
        currentState = 5'd1;
        step(9);
        userInput = 1'b1;
        step(1);
        chk("abort_early_audio", 32'(audio), 32'd1);
        chk("abort_early_complete", 32'(stateComplete), 32'd0);
        step(1);
        userInput = 1'b0;
        step(3);
        chk("abort_tick3_audio", 32'(audio), 32'd2);
        step(3);
        userInput = 1'b1;
        step(1);
        chk("abort_audio", 32'(audio), 32'd128);
        chk("abort_complete", 32'(stateComplete), 32'd1);
        chk("abort_state", 32'(dbg[23:16]), 32'd3);
        userInput = 1'b0; currentState = 5'd0;
        step(2);

        // State change mid-song 1 -> 2
        currentState = 5'd1;
        step(10);
        chk("chg_pre_audio", 32'(audio), 32'd1);
        currentState = 5'd2;
        step(1);
        chk("chg_idle_state", 32'(dbg[23:16]), 32'd0);
        chk("chg_idle_audio", 32'(audio), 32'd128);
        chk("chg_idle_complete", 32'(stateComplete), 32'd0);
        step(1);
        chk("chg_prime_state", 32'(dbg[23:16]), 32'd1);
        chk("chg_prime_addr", 32'(rom_bus.romAddress), 32'h100);
        chk("chg_prime_idx", 32'(dbg[31:24]), 32'd1);
        currentState = 5'd0;
        step(2);

        // Zero-length song
        songLength = {16'd3, 16'd0};
        currentState = 5'd1;
        step(1);
        chk("len0_prime_complete", 32'(stateComplete), 32'd0);
        step(1);
        chk("len0_done_complete", 32'(stateComplete), 32'd1);
        chk("len0_done_state", 32'(dbg[23:16]), 32'd3);
        currentState = 5'd0;
        songLength = {16'd3, 16'd5};
        step(2);

        // Asynchronous reset mid-PLAY
        currentState = 5'd1;
        step(8);
        reset_n = 1'b0;
        #1;
        chk("rst_addr", 32'(rom_bus.romAddress), 32'h0);
        chk("rst_audio", 32'(audio), 32'd128);
        chk("rst_complete", 32'(stateComplete), 32'd0);
        chk("rst_debug", dbg, 32'h0);
        step(2);
        reset_n = 1'b1;
        step(1);
        chk("rst_restart_state", 32'(dbg[23:16]), 32'd1);
        currentState = 5'd0;
        step(2);

        // Randomized run against the model
        rom_xor = int'($urandom_range(0, 255));
        step(2);
        for (int it = 0; it < 250; it++) begin
            int dur;
            currentState = 5'($urandom_range(0, 3));
            loopEnable = 1'($urandom_range(0, 1));
            volumeShift = 3'($urandom_range(0, 7));
            dur = int'($urandom_range(1, 40));
            if ($urandom_range(0, 49) == 0) begin
                reset_n = 1'b0;
                step(1);
                reset_n = 1'b1;
            end
            repeat (dur) begin
                if ($urandom_range(0, 7) == 0) userInput = ~userInput;
                step(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
